alu_md: RTL and testbench
=========================

ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 SHALL have parameter XLEN, default 32, the operand and result width; legal values are 8, 16, 32 and 64.
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), the width of the shift amount taken from src2[SHW-1:0].
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-007 SHALL have port op  input  5  operation code, encoded per REQ-012.
REQ-008 SHALL have ports src1, src2  input  XLEN each  operands.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port result  output  XLEN  registered result.

Function
REQ-012 SHALL support these op codes:
- 0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR, 5 SLT (signed), 6 SLL, 7 SRL, 8 SRA, 9 SLTU.
- 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU.
- Any other code SHALL produce result 0 with base-op latency.
REQ-013 SHALL implement a state machine with states IDLE, CALC and DONE; in_ready SHALL be 1 only in IDLE while rst is low.
REQ-014 SHALL accept a request on a rising edge where in_valid and in_ready are both 1, and SHALL latch op, src1 and src2 on that edge.
REQ-015 Base ops (0-9 and illegal codes) SHALL go IDLE->DONE; result and out_valid SHALL be valid on the first edge after acceptance (latency 1).
REQ-016 M ops (10-17) SHALL go IDLE->CALC, run exactly XLEN iterations, then go CALC->DONE; out_valid SHALL rise XLEN+1 edges after acceptance, regardless of operand values.
REQ-017 Multiply SHALL use an iterative shift-add datapath:
- MUL returns the low XLEN bits of the product.
- MULH, MULHSU and MULHU return the high XLEN bits, with signedness signed*signed, signed*unsigned and unsigned*unsigned respectively.
REQ-018 Divide SHALL use iterative restoring division on operand magnitudes; signs SHALL be fixed up at the end (quotient truncates toward zero, remainder takes the sign of the dividend).
REQ-019 Divide by zero SHALL return quotient all-ones and remainder = src1, for both signed and unsigned forms.
REQ-020 Signed overflow (src1 = most-negative value, src2 = -1) SHALL return quotient = src1 and remainder 0.
REQ-021 Shifts SHALL use src2[SHW-1:0] only; SRA SHALL replicate src1[XLEN-1].
REQ-022 ADD, SUB and MUL SHALL wrap modulo 2^XLEN; no overflow flag exists.
REQ-023 In DONE, out_valid SHALL stay 1 and result SHALL stay stable until a rising edge with out_ready=1, after which the state SHALL be IDLE.
REQ-024 in_valid asserted during CALC or DONE SHALL be ignored; the block SHALL NOT accept back-to-back requests while a result is pending.
REQ-025 Input changes after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-026 While rst=1 at a rising edge, the block SHALL:
- go to IDLE;
- clear out_valid to 0 and result to 0;
- clear all iteration counters and partial registers.
in_ready SHALL read 0 while rst is high.
REQ-027 Reset asserted during CALC or DONE SHALL abort the operation; no out_valid pulse SHALL follow for the aborted request.

Configuration
REQ-028 Macro ALU_MD_MEXT_EN: when defined, ops 10-17 SHALL behave per REQ-016 to REQ-020.
REQ-029 When ALU_MD_MEXT_EN is not defined:
- ops 10-17 SHALL be treated as illegal (result 0, latency 1);
- the CALC state and the multiply/divide datapath SHALL NOT be synthesised.

Verification
REQ-030 Reset, then ADD src1=0x7FFFFFFF, src2=1 -> one edge later out_valid=1, result=0x80000000; in_ready=0 until the out_ready handshake.
REQ-031 SRA src1=0x80000000, src2=0x00000024 (shift amount 4) -> result=0xF8000000; SLTU 1 vs 0xFFFFFFFF -> result 1.
REQ-032 MULH src1=0x80000000, src2=0x80000000 -> out_valid exactly 33 edges after acceptance, result=0x40000000; MULHSU src1=-1, src2=0xFFFFFFFF -> result=0xFFFFFFFF.
REQ-033 DIV:
- src1=-7, src2=2 -> result=-3 (0xFFFFFFFD); REM of the same operands -> 0xFFFFFFFF.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
- DIV 0x80000000 / -1 -> 0x80000000.
REQ-034 Hold out_ready=0 for 10 cycles in DONE with in_valid=1 and new operands -> result unchanged and no second acceptance; raise out_ready -> IDLE the next edge.
REQ-035 Assert rst in CALC cycle 5 of a DIVU -> IDLE and result 0 with no out_valid; a following ADD 2+3 -> result 5. Rebuild without ALU_MD_MEXT_EN: MUL -> result 0 with latency 1.

Source files
------------

// File: rtl/alu_md.sv
// Multi-cycle integer ALU: single-cycle base ops, plus iterative multiply/divide
// when the ALU_MD_MEXT_EN macro is defined (otherwise ops 10-17 are illegal and return 0).
module alu_md #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef ALU_MD_MEXT_EN
    CALC = 2'd1,
`endif
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_result;
  logic [XLEN-1:0] w_base;
  logic [SHW-1:0]  w_shamt;

  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign w_shamt   = src2[SHW-1:0];

  always_comb begin
    w_base = '0;
    case (op)
      5'd0:    w_base = src1 & src2;
      5'd1:    w_base = src1 | src2;
      5'd2:    w_base = src1 + src2;
      5'd3:    w_base = src1 - src2;
      5'd4:    w_base = src1 ^ src2;
      5'd5:    w_base[0] = $signed(src1) < $signed(src2);
      5'd6:    w_base = src1 << w_shamt;
      5'd7:    w_base = src1 >> w_shamt;
      5'd8:    w_base = $signed(src1) >>> w_shamt;
      5'd9:    w_base[0] = src1 < src2;
      default: w_base = '0;
    endcase
  end

`ifdef ALU_MD_MEXT_EN
  logic [4:0]        r_op;
  logic [XLEN-1:0]   r_src1, r_src2;
  logic [XLEN-1:0]   r_a, r_hi, r_lo;
  logic [SHW-1:0]    r_cnt;
  logic              r_neg, r_rneg;

  logic              w_is_m, w_is_div;
  logic              w_s1_signed, w_s2_signed, w_s1_neg, w_s2_neg;
  logic [XLEN-1:0]   w_mag1, w_mag2;
  logic [XLEN:0]     w_sum, w_rsh;
  logic [XLEN-1:0]   w_rdiff;
  logic              w_ge;
  logic [XLEN-1:0]   w_nhi, w_nlo, w_mres;
  logic [2*XLEN-1:0] w_prod;

  assign w_is_m      = (op >= 5'd10) && (op <= 5'd17);
  assign w_is_div    = (op >= 5'd14);
  assign w_s1_signed = (op == 5'd11) || (op == 5'd12) || (op == 5'd14) || (op == 5'd16);
  assign w_s2_signed = (op == 5'd11) || (op == 5'd14) || (op == 5'd16);
  assign w_s1_neg    = w_s1_signed & src1[XLEN-1];
  assign w_s2_neg    = w_s2_signed & src2[XLEN-1];
  assign w_mag1      = w_s1_neg ? -src1 : src1;
  assign w_mag2      = w_s2_neg ? -src2 : src2;

  // r_hi:r_lo is the product (multiply) or remainder:quotient (divide);
  // the final result is taken from the next-step values so the last iteration and writeback share an edge.
  always_comb begin
    w_sum   = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_a}) : {1'b0, r_hi};
    w_rsh   = {r_hi, r_lo[XLEN-1]};
    w_ge    = (w_rsh >= {1'b0, r_a});
    w_rdiff = w_rsh[XLEN-1:0] - r_a;
    if (r_op >= 5'd14) begin
      w_nhi = w_ge ? w_rdiff : w_rsh[XLEN-1:0];
      w_nlo = {r_lo[XLEN-2:0], w_ge};
    end else begin
      w_nhi = w_sum[XLEN:1];
      w_nlo = {w_sum[0], r_lo[XLEN-1:1]};
    end
    w_prod = r_neg ? -{w_nhi, w_nlo} : {w_nhi, w_nlo};
    case (r_op)
      5'd10:                  w_mres = w_prod[XLEN-1:0];
      5'd11, 5'd12, 5'd13:    w_mres = w_prod[2*XLEN-1:XLEN];
      5'd14, 5'd15:           w_mres = (r_src2 == '0) ? '1 : (r_neg ? -w_nlo : w_nlo);
      5'd16, 5'd17:           w_mres = (r_src2 == '0) ? r_src1 : (r_rneg ? -w_nhi : w_nhi);
      default:                w_mres = '0;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_result <= '0;
`ifdef ALU_MD_MEXT_EN
      r_op     <= '0;
      r_src1   <= '0;
      r_src2   <= '0;
      r_a      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_rneg   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
`ifdef ALU_MD_MEXT_EN
            if (w_is_m) begin
              r_op   <= op;
              r_src1 <= src1;
              r_src2 <= src2;
              r_neg  <= w_s1_neg ^ w_s2_neg;
              r_rneg <= w_s1_neg;
              r_cnt  <= '0;
              r_hi   <= '0;
              if (w_is_div) begin
                r_a  <= w_mag2;
                r_lo <= w_mag1;
              end else begin
                r_a  <= w_mag1;
                r_lo <= w_mag2;
              end
              r_state <= CALC;
            end else
`endif
            begin
              r_result <= w_base;
              r_state  <= DONE;
            end
          end
        end
`ifdef ALU_MD_MEXT_EN
        CALC: begin
          r_hi  <= w_nhi;
          r_lo  <= w_nlo;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == '1) begin
            r_result <= w_mres;
            r_state  <= DONE;
          end
        end
`endif
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// Scoreboard bench for alu_md (XLEN=32); expectations for ops 10-17 follow ALU_MD_MEXT_EN.
module tb_alu_md;
  localparam int XLEN = 32;
`ifdef ALU_MD_MEXT_EN
  localparam bit MEXT = 1'b1;
  localparam int ML   = XLEN + 1;
`else
  localparam bit MEXT = 1'b0;
  localparam int ML   = 1;
`endif

  typedef struct {
    logic [XLEN-1:0] exp;
    int              lat;
    int              c0;
    string           name;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] src1, src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  logic mon_prev = 1'b0;
  exp_t sb[$];

  alu_md #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src1(src1), .src2(src2),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every new result presentation is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && !mon_prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=0x%0h required=none", result);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_result"}, result, e.exp);
          chk({e.name, "_latency"}, cyc - e.c0, e.lat);
        end
      end
      mon_prev = out_valid;
    end
  end

  task automatic issue(input logic [4:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] exp, input int lat, input string name, input bit hold);
    exp_t e;
    int   n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout actual=in_ready0 required=in_ready1", name);
      return;
    end
    in_valid = 1'b1;
    op = o;
    src1 = a;
    src2 = b;
    e.exp = exp; e.lat = lat; e.c0 = cyc; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    src1 = $urandom;
    src2 = $urandom;
    op = 5'($urandom);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_result_timeout actual=no_out_valid required=out_valid", name);
      return;
    end
    if (!hold) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b1; in_valid = 1'b0; op = '0; src1 = '0; src2 = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    issue(5'd2, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1, "add_wrap", 0);
    issue(5'd3, 32'h0,         32'h1,         32'hFFFF_FFFF, 1, "sub_wrap", 0);
    issue(5'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1, "and", 0);
    issue(5'd1, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1, "or", 0);
    issue(5'd4, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 1, "xor", 0);
    issue(5'd5, 32'hFFFF_FFFF, 32'h1,         32'h1,         1, "slt_neg", 0);
    issue(5'd5, 32'h1,         32'hFFFF_FFFF, 32'h0,         1, "slt_pos", 0);
    issue(5'd9, 32'h1,         32'hFFFF_FFFF, 32'h1,         1, "sltu", 0);
    issue(5'd6, 32'h1,         32'h0000_0021, 32'h2,         1, "sll_mask", 0);
    issue(5'd7, 32'h8000_0000, 32'h0000_001F, 32'h1,         1, "srl", 0);
    issue(5'd8, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1, "sra", 0);
    issue(5'd18, 32'h1234,     32'h5678,      32'h0,         1, "illegal18", 0);
    issue(5'd31, 32'hFFFF,     32'hFFFF,      32'h0,         1, "illegal31", 0);

    issue(5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MEXT ? 32'h1 : 32'h0,          ML, "mul", 0);
    issue(5'd11, 32'h8000_0000, 32'h8000_0000, MEXT ? 32'h4000_0000 : 32'h0,  ML, "mulh", 0);
    issue(5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MEXT ? 32'hFFFF_FFFF : 32'h0,  ML, "mulhsu", 0);
    issue(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MEXT ? 32'hFFFF_FFFE : 32'h0,  ML, "mulhu", 0);
    issue(5'd14, 32'hFFFF_FFF9, 32'h2,         MEXT ? 32'hFFFF_FFFD : 32'h0,  ML, "div_neg", 0);
    issue(5'd16, 32'hFFFF_FFF9, 32'h2,         MEXT ? 32'hFFFF_FFFF : 32'h0,  ML, "rem_neg", 0);
    issue(5'd15, 32'h5,         32'h0,         MEXT ? 32'hFFFF_FFFF : 32'h0,  ML, "divu_zero", 0);
    issue(5'd17, 32'h5,         32'h0,         MEXT ? 32'h5 : 32'h0,          ML, "remu_zero", 0);
    issue(5'd16, 32'hFFFF_FFF9, 32'h0,         MEXT ? 32'hFFFF_FFF9 : 32'h0,  ML, "rem_zero", 0);
    issue(5'd14, 32'h8000_0000, 32'hFFFF_FFFF, MEXT ? 32'h8000_0000 : 32'h0,  ML, "div_ovf", 0);
    issue(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,                         ML, "rem_ovf", 0);
    issue(5'd15, 32'd100,       32'd7,         MEXT ? 32'd14 : 32'h0,         ML, "divu", 0);
    issue(5'd17, 32'd100,       32'd7,         MEXT ? 32'd2 : 32'h0,          ML, "remu", 0);

    // Result held in DONE while new requests are offered.
    out_ready = 1'b0;
    issue(5'd2, 32'd2, 32'd3, 32'd5, 1, "hold_add", 1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      op = 5'd2;
      src1 = $urandom;
      src2 = $urandom;
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_result", result, 5);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);

    // Abort an in-flight request with reset.
    out_ready = 1'b0;
`ifdef ALU_MD_MEXT_EN
    @(negedge clk);
    in_valid = 1'b1; op = 5'd15; src1 = 32'd100; src2 = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
`else
    issue(5'd2, 32'd9, 32'd1, 32'd10, 1, "pre_rst_add", 1);
`endif
    rst = 1'b1;
    #1;
    chk("rst_mid_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", result, 0);
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", seen, 0);
    issue(5'd2, 32'd2, 32'd3, 32'd5, 1, "add_after_rst", 0);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
